// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NREQ byte requesters
//
// Optional feature macro: UART_TX_ARB_LOCK_EN (hold-grant lock for atomic multi-byte messages).
//
// Ports:
//   clk           system clock (same as uart_tx)
//   reset         asynchronous, active-high reset
//   req           per-requester byte-valid, held with stable data until ack
//   req_data      flattened request bytes, requester i at [8i+7:8i]
//   lock          per-requester hold-grant request (used only with UART_TX_ARB_LOCK_EN)
//   ack           one-cycle pulse: requester's byte has been captured
//   grant         one-hot owner of the frame in flight, zero when idle
//   busy          high from capture until frame completion
//   tx_start      one-cycle start strobe to uart_tx
//   tx_din        byte to uart_tx, stable from tx_start to tx_done_tick
//   tx_done_tick  frame-complete pulse from uart_tx

module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   lock,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              tx_start,
    output logic [7:0]        tx_din,
    input  logic              tx_done_tick
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [7:0]      din_q, din_d;

    logic [PW-1:0]   rr_sel;
    logic            rr_found;
    logic [PW-1:0]   pick_sel;
    logic            pick_vld;
    logic [PW-1:0]   sel_next;

    // First set request searching upward from ptr, wrapping at NREQ-1.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_v;
        rr_sel   = '0;
        rr_found = 1'b0;
        idx      = 0;
        idx_v    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = PW'(idx);
            if (!rr_found && req[idx_v]) begin
                rr_sel   = idx_v;
                rr_found = 1'b1;
            end
        end
    end

    assign sel_next = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
    logic          lock_vld_q, lock_vld_d;
    logic [PW-1:0] lock_own_q, lock_own_d;
    logic          lock_hit;

    // A live lock owner with a pending byte wins regardless of ptr.
    assign lock_hit = lock_vld_q && req[lock_own_q];
    assign pick_sel = lock_hit ? lock_own_q : rr_sel;
    assign pick_vld = lock_hit | rr_found;
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign pick_sel    = rr_sel;
    assign pick_vld    = rr_found;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        din_d   = din_q;
`ifdef UART_TX_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
`ifdef UART_TX_ARB_LOCK_EN
                // Owner stopped requesting: release so round-robin applies this cycle.
                if (lock_vld_q && !req[lock_own_q]) begin
                    lock_vld_d = 1'b0;
                end
`endif
                if (pick_vld) begin
                    sel_d   = pick_sel;
                    grant_d = NREQ'(1) << pick_sel;
                    din_d   = req_data[{pick_sel, 3'b000} +: 8];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                    if (lock[sel_q]) begin
                        lock_vld_d = 1'b1;
                        lock_own_d = sel_q;
                    end else begin
                        lock_vld_d = 1'b0;
                        ptr_d      = sel_next;
                    end
`else
                    ptr_d = sel_next;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            din_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            din_q   <= din_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end
`endif

    // Strobes decode straight from the state register so reset clears them immediately.
    assign tx_start = (state_q == ST_LAUNCH);
    assign ack      = {NREQ{tx_start}} & grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant    = grant_q;
    assign tx_din   = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  lock;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;

    int cyc;
    int passed;
    int total;

    uart_tx_arbiter #(.NREQ(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .lock         (lock),
        .ack          (ack),
        .grant        (grant),
        .busy         (busy),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic apply_reset();
        reset = 1'b1;
        req = 4'b0000;
        lock = 4'b0000;
        tx_done_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for tx_start, reports the granted index and launched byte.
    task automatic wait_start(output int gidx, output logic [7:0] data, output int scyc, output bit to);
        int k;
        k = 0;
        to = 1'b0;
        gidx = -1;
        data = 8'h00;
        scyc = -1;
        while (tx_start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (tx_start !== 1'b1) begin
            to = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant === (4'b0001 << i)) gidx = i;
            end
            data = tx_din;
            scyc = cyc;
        end
    endtask

    // Plays uart_tx for one frame: two WAIT cycles, then a done tick.
    task automatic finish_frame(output int dcyc, output bit hold_ok, output bit pulse_ok, output bit idle_ok);
        logic [7:0] d0;
        logic [3:0] g0;
        d0 = tx_din;
        g0 = grant;
        @(negedge clk);
        pulse_ok = (ack === 4'b0000) && (tx_start === 1'b0) && (busy === 1'b1);
        hold_ok = 1'b1;
        repeat (2) begin
            if (tx_din !== d0 || grant !== g0 || busy !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
        end
        tx_done_tick = 1'b1;
        dcyc = cyc;
        @(negedge clk);
        tx_done_tick = 1'b0;
        idle_ok = (grant === 4'b0000) && (busy === 1'b0) && (ack === 4'b0000);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({grant, ack, busy, tx_start, tx_din} !== 18'h0)
            $display("FAIL reset_outputs got grant=%b ack=%b busy=%b start=%b din=%h want all zero",
                     grant, ack, busy, tx_start, tx_din);
        else passed++;
        apply_reset();
    endtask

    task automatic test_single();
        int gidx, scyc, dcyc, rcyc;
        logic [7:0] data;
        bit to, hold_ok, pulse_ok, idle_ok;
        req_data = 32'h00A5_0000;
        req = 4'b0100;
        rcyc = cyc;
        wait_start(gidx, data, scyc, to);
        total++;
        if (to) $display("FAIL single_timeout got no tx_start want tx_start"); else passed++;
        total++;
        if (gidx !== 2) $display("FAIL single_grant got %0d want 2", gidx); else passed++;
        total++;
        if (ack !== 4'b0100) $display("FAIL single_ack got %b want 0100", ack); else passed++;
        total++;
        if (data !== 8'hA5) $display("FAIL single_din got %h want a5", data); else passed++;
        total++;
        if (scyc - rcyc !== 1) $display("FAIL single_latency got %0d want 1", scyc - rcyc); else passed++;
        req = 4'b0000;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        total++;
        if (!hold_ok) $display("FAIL single_hold got unstable want stable din/grant/busy"); else passed++;
        total++;
        if (!pulse_ok) $display("FAIL single_pulse got ack/start longer than 1 cycle want 1"); else passed++;
        total++;
        if (!idle_ok) $display("FAIL single_idle got grant=%b busy=%b want 0000/0", grant, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int gidx, scyc, dcyc, prev_d;
        logic [7:0] data;
        bit to, hold_ok, pulse_ok, idle_ok;
        apply_reset();
        req_data = 32'h1312_1110;
        req = 4'b1111;
        prev_d = -1;
        for (int f = 0; f < 5; f++) begin
            wait_start(gidx, data, scyc, to);
            total++;
            if (to || gidx !== (f % 4))
                $display("FAIL contention_grant frame %0d got %0d want %0d", f, gidx, f % 4);
            else passed++;
            total++;
            if (data !== 8'h10 + 8'(f % 4))
                $display("FAIL contention_din frame %0d got %h want %h", f, data, 8'h10 + 8'(f % 4));
            else passed++;
            if (f > 0) begin
                total++;
                if (scyc - prev_d !== 2)
                    $display("FAIL contention_gap frame %0d got %0d want 2", f, scyc - prev_d);
                else passed++;
            end
            finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
            prev_d = dcyc;
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int gidx, scyc, dcyc;
        logic [7:0] data;
        bit to, hold_ok, pulse_ok, idle_ok;
        apply_reset();
        req_data = 32'h0000_3130;
        req = 4'b0010;
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        total++;
        if (to || gidx !== 1) $display("FAIL fair_setup got %0d want 1", gidx); else passed++;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        req = 4'b0011;
        wait_start(gidx, data, scyc, to);
        total++;
        if (to || gidx !== 0) $display("FAIL fair_first got %0d want 0", gidx); else passed++;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        total++;
        if (to || gidx !== 1 || data !== 8'h31) $display("FAIL fair_second got %0d/%h want 1/31", gidx, data); else passed++;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
    endtask

    task automatic test_lock();
        int gidx, scyc, dcyc, r1cnt, nexp;
        int exp_seq[7];
        logic [7:0] data;
        bit to, hold_ok, pulse_ok, idle_ok;
`ifdef UART_TX_ARB_LOCK_EN
        exp_seq = '{1, 1, 1, 3, 0, 0, 0};
        nexp = 4;
`else
        exp_seq = '{1, 3, 0, 1, 3, 0, 1};
        nexp = 7;
`endif
        apply_reset();
        // Serve requester 0 once so the search starts at requester 1.
        req_data = 32'h4300_2140;
        req = 4'b0001;
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        req = 4'b1011;
        lock = 4'b0010;
        r1cnt = 0;
        for (int f = 0; f < nexp; f++) begin
            wait_start(gidx, data, scyc, to);
            total++;
            if (to || gidx !== exp_seq[f])
                $display("FAIL lock_order frame %0d got %0d want %0d", f, gidx, exp_seq[f]);
            else passed++;
            if (gidx == 1) begin
                r1cnt++;
                total++;
                if (data !== 8'h20 + 8'(r1cnt))
                    $display("FAIL lock_r1_byte %0d got %h want %h", r1cnt, data, 8'h20 + 8'(r1cnt));
                else passed++;
                if (r1cnt == 3) begin
                    req[1] = 1'b0;
                    lock[1] = 1'b0;
                end else begin
                    req_data[15:8] = 8'h21 + 8'(r1cnt);
                end
            end
            finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        end
        req = 4'b0000;
        lock = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int gidx, scyc, dcyc;
        logic [7:0] data;
        bit to, hold_ok, pulse_ok, idle_ok;
        apply_reset();
        req_data = 32'h5300_5100;
        req = 4'b0010;
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        req_data = 32'h5362_5100;
        req = 4'b0100;
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || grant !== 4'b0100) $display("FAIL midframe_wait got busy=%b grant=%b want 1/0100", busy, grant); else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || tx_din !== 8'h00 || tx_start !== 1'b0 || ack !== 4'b0000)
            $display("FAIL midframe_reset got grant=%b busy=%b din=%h want 0000/0/00", grant, busy, tx_din);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1010;
        wait_start(gidx, data, scyc, to);
        req = 4'b1000;
        total++;
        if (to || gidx !== 1 || data !== 8'h51) $display("FAIL midframe_ptr got %0d/%h want 1/51", gidx, data); else passed++;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        total++;
        if (to || gidx !== 3 || data !== 8'h53) $display("FAIL midframe_next got %0d/%h want 3/53", gidx, data); else passed++;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
    endtask

    task automatic test_spurious_done();
        int gidx, scyc, dcyc;
        logic [7:0] data;
        bit to, hold_ok, pulse_ok, idle_ok, quiet;
        apply_reset();
        req_data = 32'h0000_7170;
        req = 4'b0010;
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            if (ack !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!quiet) $display("FAIL spurious_quiet got activity want none"); else passed++;
        req = 4'b0011;
        wait_start(gidx, data, scyc, to);
        total++;
        if (to || gidx !== 0 || data !== 8'h70) $display("FAIL spurious_ptr got %0d/%h want 0/70", gidx, data); else passed++;
        req = 4'b0010;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
        wait_start(gidx, data, scyc, to);
        req = 4'b0000;
        total++;
        if (to || gidx !== 1) $display("FAIL spurious_next got %0d want 1", gidx); else passed++;
        finish_frame(dcyc, hold_ok, pulse_ok, idle_ok);
    endtask

    initial begin
        passed = 0;
        total = 0;
        reset = 1'b1;
        req = 4'b0000;
        req_data = 32'h0;
        lock = 4'b0000;
        tx_done_tick = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_lock();
        test_reset_midframe();
        test_spurious_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
